// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//
// Serial transmit stage. Takes one parallel word per accepted write and
// shifts it out LSB-first as an asynchronous frame:
//   start (0), DATA_W data bits, optional parity bit, stop (1).
// Bit timing comes from the oversampled baud tick produced by the upstream
// clock-enable stage: OVERSAMPLE baud_en pulses make one bit period.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit (XOR of the data word, XOR PARITY_ODD) is sent
//                between the last data bit and the stop bit.
//   undefined -> no parity bit; PARITY_ODD has no effect.
//
// Parameters:
//   DATA_W      data bits per frame (5..8)
//   OVERSAMPLE  baud_en pulses per bit period (2..16)
//   PARITY_ODD  parity sense when parity is built in (0 = even, 1 = odd)
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   baud_en  in   one-clk oversampled baud tick
//   tx_en    in   transmitter enable; low blocks new frames only
//   tx_wr    in   write strobe, sampled every clk edge
//   tx_data  in   word to send, captured on an accepted write
//   tx_d     out  serial line, idle high
//   tx_busy  out  high from the accepting edge until the stop bit ends
//   tx_done  out  one-clk pulse at the end of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_en,
  input  logic              tx_en,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_d,
  output logic              tx_busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST  = 3'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q,   cnt_d;
  logic [2:0]        idx_q,   idx_d;
  logic [DATA_W-1:0] sr_q,    sr_d;
  logic              txd_q,   txd_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              bit_end;

`ifdef UART_TX_PARITY_EN
  logic              par_q,   par_d;
`else
  // PARITY_ODD has no effect in this build; tie it off explicitly.
  logic              unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Last oversample tick of the current bit period.
  assign bit_end = baud_en && (cnt_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // The tick counter only runs while a frame is on the line.
    if (state_q != IDLE && baud_en) begin
      cnt_d = bit_end ? 4'd0 : cnt_q + 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (tx_wr && tx_en) begin
          sr_d    = tx_data;
          cnt_d   = 4'd0;
          idx_d   = 3'd0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          // Parity from the captured word, not from the shifting register.
          par_d   = (^tx_data) ^ PARITY_ODD[0];
`endif
        end
      end

      START: begin
        if (bit_end) begin
          txd_d   = sr_q[0];
          sr_d    = sr_q >> 1;
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = PARITY;
`else
            txd_d   = 1'b1;
            state_d = STOP;
`endif
          end else begin
            txd_d = sr_q[0];
            sr_d  = sr_q >> 1;
            idx_d = idx_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      sr_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_d    = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
